// File: rtl/uart_tx_sched_if.sv
// Requester byte streams plus the transmitter holding-register handshake.
// The scheduler takes the slave modport; whatever drives the sources and the UART takes master.
interface uart_tx_sched_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]   src_valid;
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_last;
    logic [N_SRC-1:0]   src_ready;
    logic               uart_data_ready;
    logic [7:0]         uart_data;
    logic               uart_data_accepted;

    modport master (
        output src_valid, src_data, src_last, uart_data_accepted,
        input  src_ready, uart_data_ready, uart_data
    );

    modport slave (
        input  src_valid, src_data, src_last, uart_data_accepted,
        output src_ready, uart_data_ready, uart_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler feeding one UART transmitter, plus its baud strobe.
// Latency: valid seen in IDLE -> src_ready next cycle -> uart_data_ready the cycle after.
// Backpressure: one byte staged; a source is only readied in CAPTURE, which waits for the UART accept.
module uart_tx_sched #(
    parameter  int N_SRC         = 4,
    parameter  int CLKS_PER_BAUD = 868,
    localparam int GW            = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave bus,
    output logic           baud_edge,
    output logic           busy,
    output logic [GW-1:0]  grant
);
    localparam int            BW        = $clog2(CLKS_PER_BAUD);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BAUD - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;

    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [7:0]    hold_q, hold_d;
    logic          last_flag_q, last_flag_d;
    logic          pick_vld;
    logic [GW-1:0] pick_idx;
    int            scan_idx;

    assign baud_cnt_d = (baud_cnt_q == BAUD_LAST) ? '0 : baud_cnt_q + BW'(1);

    // Rotating priority: first valid source strictly after the last completed grant.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = 0;
        for (int i = 1; i <= N_SRC; i++) begin
            scan_idx = (int'(last_grant_q) + i) % N_SRC;
            if (!pick_vld && bus.src_valid[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        last_flag_d  = last_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.src_valid[grant_q]) begin
                    hold_d      = bus.src_data[{grant_q, 3'b000} +: 8];
                    last_flag_d = bus.src_last[grant_q];
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.uart_data_accepted) begin
                    if (last_flag_q) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.src_ready = '0;
        if (state_q == ST_CAPTURE) begin
            bus.src_ready[grant_q] = 1'b1;
        end
    end

    assign bus.uart_data_ready = (state_q == ST_SEND);
    assign bus.uart_data       = hold_q;
    assign busy                = (state_q != ST_IDLE);
    assign grant               = grant_q;
    assign baud_edge           = (baud_cnt_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_SRC - 1);
            hold_q       <= '0;
            last_flag_q  <= 1'b0;
        end else begin
            baud_cnt_q   <= baud_cnt_d;
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            last_flag_q  <= last_flag_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: cycle table plus packet-level sequences with a UART responder.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int NV  = 22;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] last;
        logic [7:0] d0;
        logic       acc;
        logic [3:0] e_rdy;
        logic       e_udr;
        logic [7:0] e_ud;
        logic       e_busy;
        logic [1:0] e_grant;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_edge;
    logic       busy;
    logic [1:0] grant;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.N_SRC(N)) bus ();

    uart_tx_sched #(.N_SRC(N), .CLKS_PER_BAUD(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .baud_edge (baud_edge),
        .busy      (busy),
        .grant     (grant)
    );

    int         errors = 0;
    int         checks = 0;
    logic [8:0] mem [4][32];
    int         head [4];
    int         tail [4];
    logic [3:0] hold_off;
    int         acc_delay;
    int         udr_cnt;
    int         early;
    logic [9:0] got [$];
    vec_t       tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_byte(input int s, input logic [7:0] d, input logic l);
        mem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i]        = (head[i] != tail[i]) && !hold_off[i];
            bus.src_data[8*i +: 8]  = mem[i][head[i]][7:0];
            bus.src_last[i]         = mem[i][head[i]][8];
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        hold_off = '0;
        udr_cnt  = 0;
        early    = 0;
        got.delete();
        bus.uart_data_accepted = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle of the source models and the UART responder.
    task automatic dstep();
        logic [3:0] fire;
        @(negedge clk);
        fire = bus.src_valid & bus.src_ready;
        if (bus.src_ready[1] && head[0] != tail[0]) early++;
        if (bus.uart_data_ready) begin
            if (udr_cnt >= acc_delay) begin
                bus.uart_data_accepted = 1'b1;
                got.push_back({grant, bus.uart_data});
                udr_cnt = 0;
            end else begin
                udr_cnt++;
            end
        end
        @(posedge clk);
        #1;
        bus.uart_data_accepted = 1'b0;
        for (int i = 0; i < N; i++) if (fire[i]) head[i]++;
        drive_inputs();
    endtask

    function automatic logic all_empty();
        logic e = 1'b1;
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) e = 1'b0;
        return e;
    endfunction

    task automatic run_until_empty(input int budget, input string name);
        int n = 0;
        while (!(all_empty() && !busy) && n < budget) begin
            dstep();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic chk_got(input string name, input int k, input logic [9:0] exp);
        chk($sformatf("%s[%0d]", name, k), (k < got.size()) ? {22'd0, got[k]} : 32'hDEAD, {22'd0, exp});
    endtask

    initial begin
        logic [9:0] ea [6];
        logic [9:0] ec [4];
        int         n;

        for (int i = 0; i < N; i++) for (int j = 0; j < 32; j++) mem[i][j] = '0;
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.src_data  = '0;
        bus.uart_data_accepted = 1'b0;

        //            rst   vld      last     d0     acc | rdy      udr   ud     busy  grant
        tbl[0]  = '{1'b0, 4'b0001, 4'b0001, 8'h55, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 8'h55, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd0};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 4'b0011, 4'b0000, 8'h11, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 4'b0011, 4'b0000, 8'h11, 1'b0, 4'b0010, 1'b0, 8'h55, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 4'b0011, 4'b0000, 8'h11, 1'b1, 4'b0000, 1'b1, 8'hE1, 1'b1, 2'd1};
        tbl[11] = '{1'b0, 4'b0011, 4'b0000, 8'h11, 1'b0, 4'b0010, 1'b0, 8'hE1, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 4'b0011, 4'b0000, 8'h11, 1'b0, 4'b0000, 1'b1, 8'hE1, 1'b1, 2'd1};
        tbl[13] = '{1'b0, 4'b0011, 4'b0000, 8'h11, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 4'b0011, 4'b0001, 8'h66, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0};
        tbl[15] = '{1'b0, 4'b0010, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h66, 1'b1, 2'd0};
        tbl[16] = '{1'b0, 4'b0010, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h66, 1'b0, 2'd0};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0010, 1'b0, 8'h66, 1'b1, 2'd1};
        tbl[18] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0010, 1'b0, 8'h66, 1'b1, 2'd1};
        tbl[19] = '{1'b0, 4'b0010, 4'b0010, 8'h00, 1'b0, 4'b0010, 1'b0, 8'h66, 1'b1, 2'd1};
        tbl[20] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'hE1, 1'b1, 2'd1};
        tbl[21] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'hE1, 1'b0, 2'd1};

        // Cycle table: single byte, stray accepts, lock in CAPTURE, reset mid-packet.
        reset_all();
        for (int r = 0; r < NV; r++) begin
            rst                    = tbl[r].rst;
            bus.src_valid          = tbl[r].vld;
            bus.src_last           = tbl[r].last;
            bus.src_data           = {8'hE3, 8'hE2, 8'hE1, tbl[r].d0};
            bus.uart_data_accepted = tbl[r].acc;
            @(negedge clk);
            chk($sformatf("row%0d src_ready", r), {28'd0, bus.src_ready}, {28'd0, tbl[r].e_rdy});
            chk($sformatf("row%0d uart_data_ready", r), {31'd0, bus.uart_data_ready}, {31'd0, tbl[r].e_udr});
            chk($sformatf("row%0d uart_data", r), {24'd0, bus.uart_data}, {24'd0, tbl[r].e_ud});
            chk($sformatf("row%0d busy", r), {31'd0, busy}, {31'd0, tbl[r].e_busy});
            chk($sformatf("row%0d grant", r), {30'd0, grant}, {30'd0, tbl[r].e_grant});
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.uart_data_accepted = 1'b0;

        // Two 3-byte packets on sources 0 and 2: no interleaving, source 0 first.
        reset_all();
        acc_delay = 2;
        add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b0); add_byte(0, 8'hA2, 1'b1);
        add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b0); add_byte(2, 8'hC2, 1'b1);
        drive_inputs();
        run_until_empty(200, "pkt2");
        ea = '{{2'd0, 8'hA0}, {2'd0, 8'hA1}, {2'd0, 8'hA2}, {2'd2, 8'hC0}, {2'd2, 8'hC1}, {2'd2, 8'hC2}};
        chk("pkt2 count", got.size(), 6);
        for (int k = 0; k < 6; k++) chk_got("pkt2", k, ea[k]);

        // All four sources with 1-byte packets: strict rotation 0,1,2,3.
        reset_all();
        acc_delay = 0;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) add_byte(s, {4'(s), 4'(p)}, 1'b1);
        drive_inputs();
        run_until_empty(300, "rr");
        chk("rr count", got.size(), 12);
        for (int k = 0; k < 12; k++) chk_got("rr", k, {2'(k % 4), 4'(k % 4), 4'(k / 4)});

        // Granted source stalls 50 cycles mid-packet while source 1 waits.
        reset_all();
        acc_delay = 1;
        add_byte(0, 8'h10, 1'b0); add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h12, 1'b1);
        add_byte(1, 8'h20, 1'b1);
        drive_inputs();
        n = 0;
        while (head[0] < 1 && n < 20) begin
            dstep();
            n++;
        end
        chk("stall first byte taken", (head[0] >= 1) ? 32'd1 : 32'd0, 32'd1);
        hold_off[0] = 1'b1;
        drive_inputs();
        repeat (50) dstep();
        chk("stall src_ready", {28'd0, bus.src_ready}, 32'h1);
        chk("stall busy", {31'd0, busy}, 32'd1);
        chk("stall grant", {30'd0, grant}, 32'd0);
        hold_off[0] = 1'b0;
        drive_inputs();
        run_until_empty(200, "stall");
        chk("stall src1 readied early", early, 0);
        ec = '{{2'd0, 8'h10}, {2'd0, 8'h11}, {2'd0, 8'h12}, {2'd1, 8'h20}};
        for (int k = 0; k < 4; k++) chk_got("stall", k, ec[k]);

        // Baud strobe after reset release with CLKS_PER_BAUD=4.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("baud_edge c%0d", c), {31'd0, baud_edge}, (c % 4 == 3) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
